nn_stream_loader: RTL



---
 rtl/nn_pkg.sv | 24 ++
 rtl/nn_stream_addr_gen.sv | 37 +++
 rtl/nn_stream_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants, state encoding and config-image layout for the neural_network stream loader.
package nn_pkg;

    localparam int unsigned NN_INPUTS           = 4;
    localparam int unsigned NN_NEURONS          = 4;
    localparam int unsigned NN_BYTES_PER_NEURON = 6;
    localparam int unsigned NN_CFG_BYTES        = 28;

    // Byte offsets inside one neuron's block
    localparam int unsigned OFS_TH = 0;
    localparam int unsigned OFS_B  = 1;
    localparam int unsigned OFS_W0 = 2;

    typedef enum logic [2:0] {
        IDLE,
        SEND_X,
        SEND_P,
        LATCH_P,
        WAIT,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/nn_stream_addr_gen.sv
// Maps (phase, neuron, byte position) to the config-image address in the order the
// network expects to receive bytes.
module nn_stream_addr_gen
    import nn_pkg::*;
(
    input  state_t     phase,
    input  logic [1:0] neuron,
    input  logic [2:0] byte_idx,
    output logic [4:0] addr
);

    logic [5:0] base;
    logic [5:0] ofs;

    always_comb begin
        base = 6'(NN_INPUTS) + 6'(NN_BYTES_PER_NEURON) * {4'b0, neuron};
        ofs  = '0;
        addr = '0;
        case (phase)
            SEND_X: begin
                // Inputs go out highest index first
                addr = 5'(NN_INPUTS - 1) - {3'b0, byte_idx[1:0]};
            end
            SEND_P: begin
                case (byte_idx)
                    3'd0:    ofs = 6'(OFS_TH);
                    3'd1:    ofs = 6'(OFS_B);
                    // Weights go out w_n3 first, down to w_n0
                    default: ofs = 6'(OFS_W0) + (6'd5 - {3'b0, byte_idx});
                endcase
                addr = 5'(base + ofs);
            end
            default: addr = '0;
        endcase
    end

endmodule

// File: rtl/nn_stream_loader.sv
// Host-side sequencer: streams the 28-byte config image into neural_network, waits for it
// to settle, then sweeps the output selector and captures the four results.
module nn_stream_loader
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned WAIT_CYC   = 2,
    parameter int unsigned SEL_SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [4:0]          cfg_addr,
    input  logic [DATA_W-1:0]   cfg_wdata,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   nn_data_out,
    output logic                nn_changes,
    output logic [1:0]          nn_selector,
    input  logic [DATA_W-1:0]   nn_result_in,
    output logic [4*DATA_W-1:0] results
);

    state_t              state_q, state_d;
    logic [2:0]          byte_q, byte_d;
    logic [1:0]          nrn_q, nrn_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                chg_q, chg_d;
    logic                capture;
    logic                cfg_wr;
    logic [4:0]          rd_addr;
    logic [DATA_W-1:0]   cfg_q [NN_CFG_BYTES];
    logic [4*DATA_W-1:0] res_q;

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign nn_data_out = data_q;
    assign nn_changes  = chg_q;
    assign nn_selector = sel_q;
    assign results     = res_q;

    assign cfg_wr = cfg_we && !busy && (cfg_addr < 5'(NN_CFG_BYTES));

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        nrn_d   = nrn_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND_X;
                    byte_d  = '0;
                end
            end
            SEND_X: begin
                if (byte_q == 3'd3) begin
                    state_d = SEND_P;
                    byte_d  = '0;
                    nrn_d   = 2'd3;
                end else begin
                    byte_d = byte_q + 3'd1;
                end
            end
            SEND_P: begin
                if (byte_q == 3'd5) begin
                    byte_d = '0;
                    if (nrn_q == 2'd0) state_d = LATCH_P;
                    else               nrn_d   = nrn_q - 2'd1;
                end else begin
                    byte_d = byte_q + 3'd1;
                end
            end
            LATCH_P: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == 4'(WAIT_CYC - 1)) begin
                    state_d = READ;
                    cnt_d   = '0;
                    sel_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            READ: begin
                if (cnt_q == 4'(SEL_SETTLE)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    if (sel_q == 2'd3) begin
                        state_d = DONE;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = start ? SEND_X : IDLE;
                byte_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address is derived from the next position so the byte lands in the output register
    // in the same cycle the FSM enters that position.
    nn_stream_addr_gen u_addr_gen (
        .phase    (state_d),
        .neuron   (nrn_d),
        .byte_idx (byte_d),
        .addr     (rd_addr)
    );

    always_comb begin
        data_d = '0;
        case (state_d)
            SEND_X, SEND_P: data_d = cfg_q[rd_addr];
            LATCH_P:        data_d = data_q;
            default:        data_d = '0;
        endcase
        chg_d = ((state_d == SEND_X) && (byte_d == 3'd3)) || (state_d == LATCH_P);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            byte_q  <= '0;
            nrn_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            chg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            nrn_q   <= nrn_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            chg_q   <= chg_d;
            if (capture) res_q[32'(sel_q) * DATA_W +: DATA_W] <= nn_result_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NN_CFG_BYTES); i++) cfg_q[i] <= '0;
        end else if (cfg_wr) begin
            cfg_q[cfg_addr] <= cfg_wdata;
        end
    end

endmodule
